sort_reader: RTL and testbench

- Read-side consumer of the 8-entry nibble register file in the sort datapath.
- On `start`, snapshots the eight parallel entry outputs and sorts them with an odd-even transposition network, one phase per cycle.
- Then streams the sorted values out one beat at a time over a valid/ready handshake, with index and last flags.
- Sits between the register file and the downstream display/serialiser logic.

---
 rtl/sort_pkg.sv | 9 +
 rtl/sort_cas.sv | 16 +
 rtl/sort_reader.sv | 118 +++++++++++
 tb/tb_sort_reader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared constants and state encoding for the register-file sort reader.
package sort_pkg;
  localparam int DW         = 4;
  localparam int N          = 8;
  localparam int IW         = 3;
  localparam int NUM_PHASES = N;

  typedef enum logic [1:0] {IDLE, SORT, STREAM} state_e;
endpackage

// File: rtl/sort_cas.sv
// Compare-and-swap cell: lo/hi come out in the requested order, ties pass through.
module sort_cas
  import sort_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          desc,
  output logic [DW-1:0] lo,
  output logic [DW-1:0] hi
);
  logic swap;

  assign swap = desc ? (a < b) : (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/sort_reader.sv
// Snapshots eight register-file entries, sorts them with an odd-even
// transposition network (one phase per cycle), then streams them out.
module sort_reader
  import sort_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          desc,
  input  logic [DW-1:0] zero,
  input  logic [DW-1:0] one,
  input  logic [DW-1:0] two,
  input  logic [DW-1:0] three,
  input  logic [DW-1:0] four,
  input  logic [DW-1:0] five,
  input  logic [DW-1:0] six,
  input  logic [DW-1:0] seven,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          done
);
  state_e                 state_q, state_d;
  logic [N-1:0][DW-1:0]   arr_q, arr_d;
  logic [N-1:0][DW-1:0]   ent, even_nx, odd_nx;
  logic [IW-1:0]          phase_q, phase_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   desc_q, desc_d;
  logic                   done_q, done_d;

  assign ent = {seven, six, five, four, three, two, one, zero};

  // Dedicated cells per phase parity; the odd phase leaves both ends untouched.
  for (genvar g = 0; g < N/2; g++) begin : g_even
    sort_cas u_cas (
      .a(arr_q[2*g]), .b(arr_q[2*g+1]), .desc(desc_q),
      .lo(even_nx[2*g]), .hi(even_nx[2*g+1])
    );
  end

  for (genvar g = 0; g < N/2-1; g++) begin : g_odd
    sort_cas u_cas (
      .a(arr_q[2*g+1]), .b(arr_q[2*g+2]), .desc(desc_q),
      .lo(odd_nx[2*g+1]), .hi(odd_nx[2*g+2])
    );
  end
  assign odd_nx[0]   = arr_q[0];
  assign odd_nx[N-1] = arr_q[N-1];

  always_comb begin
    state_d = state_q;
    arr_d   = arr_q;
    phase_d = phase_q;
    ptr_d   = ptr_q;
    desc_d  = desc_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          arr_d   = ent;
          desc_d  = desc;
          phase_d = '0;
          state_d = SORT;
        end
      end
      SORT: begin
        arr_d   = phase_q[0] ? odd_nx : even_nx;
        phase_d = phase_q + 1'b1;
        if (phase_q == IW'(NUM_PHASES-1)) begin
          phase_d = '0;
          ptr_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (ptr_q == IW'(N-1)) begin
            ptr_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      arr_q   <= '0;
      phase_q <= '0;
      ptr_q   <= '0;
      desc_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arr_q   <= arr_d;
      phase_q <= phase_d;
      ptr_q   <= ptr_d;
      desc_q  <= desc_d;
      done_q  <= done_d;
    end
  end

  // Data is gated so the bus reads zero whenever no beat is offered.
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? arr_q[ptr_q] : '0;
  assign out_idx   = ptr_q;
  assign out_last  = out_valid && (ptr_q == IW'(N-1));
  assign done      = done_q;
endmodule

// File: tb/tb_sort_reader.sv
// Randomized bench for sort_reader against a queue-sort reference model.
module tb_sort_reader;
  import sort_pkg::*;

  typedef logic [3:0] vec_t [8];

  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, desc = 1'b0, out_ready = 1'b1;
  logic [3:0] ent [8];
  logic       busy, out_valid, out_last, done;
  logic [3:0] out_data;
  logic [2:0] out_idx;

  sort_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .desc(desc),
    .zero(ent[0]), .one(ent[1]), .two(ent[2]), .three(ent[3]),
    .four(ent[4]), .five(ent[5]), .six(ent[6]), .seven(ent[7]),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 sorting, 2 streaming
  int  m_mode = 0, m_cnt = 0, m_idx = 0;
  bit  m_done = 0;
  int  m_exp[$];
  int  log_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_idx = 0; m_done = 0;
      m_exp.delete();
    end else begin
      bit dn;
      dn = 0;
      case (m_mode)
        0: if (start) begin
          m_exp.delete();
          for (int i = 0; i < 8; i++) m_exp.push_back(int'(ent[i]));
          if (desc) m_exp.rsort(); else m_exp.sort();
          m_mode = 1; m_cnt = 0;
        end
        1: begin
          m_cnt++;
          if (m_cnt == 8) begin m_mode = 2; m_idx = 0; end
        end
        default: if (out_ready) begin
          if (m_idx == 7) begin m_mode = 0; m_idx = 0; dn = 1; end
          else m_idx++;
        end
      endcase
      m_done = dn;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_mode != 0);
      chk("out_valid", out_valid, m_mode == 2);
      chk("done", done, m_done);
      if (m_mode == 2) begin
        chk("out_data", out_data, m_exp[m_idx]);
        chk("out_idx", out_idx, m_idx);
        chk("out_last", out_last, m_idx == 7);
        if (out_ready) log_q.push_back(int'(out_data));
      end else begin
        chk("out_last_idle", out_last, 0);
      end
    end
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("wait_valid_timeout", out_valid, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("wait_done_timeout", done, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_idx"}, out_idx, 0);
    chk({nm, "_last"}, out_last, 0);
  endtask

  // lat: edges after the start edge until out_valid; dn: edges until done
  task automatic run_sort(input vec_t v, input bit d, output int lat, output int dn);
    log_q.delete();
    for (int i = 0; i < 8; i++) ent[i] = v[i];
    desc = d; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    dn = lat;
    while (!done && dn < 400) begin tick(); dn++; end
    chk("run_done_timeout", done, 1);
    tick();
  endtask

  task automatic chk_log(input string nm, input vec_t want);
    chk({nm, "_count"}, log_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) chk(nm, log_q[i], want[i]);
  endtask

  task automatic sorted_of(input vec_t v, input bit d, output vec_t s);
    int q[$];
    for (int i = 0; i < 8; i++) q.push_back(int'(v[i]));
    if (d) q.rsort(); else q.sort();
    for (int i = 0; i < 8; i++) s[i] = 4'(q[i]);
  endtask

  initial begin
    vec_t v, w;
    int lat, dn, n;
    for (int i = 0; i < 8; i++) ent[i] = '0;
    #1;
    chk_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ascending, with latency pinned by hand
    v = '{4'd7, 4'd3, 4'd5, 4'd1, 4'd6, 4'd0, 4'd4, 4'd2};
    run_sort(v, 1'b0, lat, dn);
    chk("asc_latency", lat, 9);
    chk("asc_done_edges", dn, 17);
    w = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    chk_log("asc_beats", w);

    // Descending with duplicates
    v = '{4'h4, 4'h4, 4'hF, 4'h0, 4'h4, 4'h0, 4'hF, 4'h1};
    run_sort(v, 1'b1, lat, dn);
    w = '{4'hF, 4'hF, 4'h4, 4'h4, 4'h4, 4'h1, 4'h0, 4'h0};
    chk_log("desc_dup_beats", w);

    // Backpressure with random stalls
    rand_ready = 1;
    for (int k = 0; k < 8; k++) begin
      bit d;
      for (int i = 0; i < 8; i++) v[i] = 4'($urandom_range(0, 15));
      d = 1'($urandom_range(0, 1));
      run_sort(v, d, lat, dn);
      sorted_of(v, d, w);
      chk_log("bp_beats", w);
    end
    rand_ready = 0;
    tick();

    // start ignored while busy; entries rewritten during SORT
    log_q.delete();
    v = '{4'd9, 4'd2, 4'd11, 4'd2, 4'd0, 4'd15, 4'd6, 4'd3};
    for (int i = 0; i < 8; i++) ent[i] = v[i];
    desc = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int i = 0; i < 8; i++) ent[i] = 4'hF;
    desc = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    tick(); tick();
    start = 1'b1;
    wait_done();
    start = 1'b0;
    tick(); tick();
    chk("busy_after_ignored_start", busy, 0);
    sorted_of(v, 1'b0, w);
    chk_log("isolation_beats", w);

    // Reset mid-SORT at phase 3
    v = '{4'd5, 4'd1, 4'd8, 4'd3, 4'd12, 4'd7, 4'd2, 4'd9};
    for (int i = 0; i < 8; i++) ent[i] = v[i];
    desc = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_sort");
    tick();
    rst_n = 1'b1;
    tick();

    // Reset in STREAM at ptr=4
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    n = 0;
    while (out_idx != 3'd4 && n < 40) begin tick(); n++; end
    chk("reach_ptr4", out_idx, 4);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_stream");
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("no_done_after_rst", done, 0);

    run_sort(v, 1'b1, lat, dn);
    sorted_of(v, 1'b1, w);
    chk_log("post_rst_beats", w);
    chk("post_rst_latency", lat, 9);

    // Already sorted input and all-zero input
    v = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    run_sort(v, 1'b0, lat, dn);
    chk_log("presorted_beats", v);
    v = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    run_sort(v, 1'b0, lat, dn);
    chk_log("zero_beats", v);
    chk("zero_done_edges", dn, 17);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
